// File: rtl/nn_pkg.sv
// Shared type definitions for the neural-network datapath blocks.
package nn_pkg;

    // Per-neuron sequencing states used by the neuron blocks.
    typedef enum logic [1:0] {
        NEURON_IDLE  = 2'd0,
        NEURON_ACCUM = 2'd1,
        NEURON_ACT   = 2'd2
    } neuron_state_t;

    // Argmax sequencing: gather the layer, walk it once, hold the result.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/layer_argmax.sv
// Captures one output-layer vector as each neuron reports, walks it one
// element per cycle to find the largest value (lowest index on ties), and
// presents the winning class on a valid/ready port.
module layer_argmax
    import nn_pkg::*;
#(
    parameter int numNeurons = 10,
    parameter int dataWidth  = 8,
    localparam int indexWidth = $clog2(numNeurons)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic [numNeurons*dataWidth-1:0] layerIn,
    input  logic [numNeurons-1:0]           layerInValid,
    output logic [indexWidth-1:0]           classOut,
    output logic [dataWidth-1:0]            maxOut,
    output logic                            classValid,
    input  logic                            classReady,
    output logic                            busy
);

    argmax_state_t          state;
    logic [numNeurons-1:0]  gotFlag;
    logic [numNeurons-1:0]  capEn;
    logic [dataWidth-1:0]   capReg [numNeurons];
    logic [indexWidth-1:0]  scanIdx;
    logic [indexWidth-1:0]  bestIdx;
    logic [dataWidth-1:0]   bestVal;
    logic [dataWidth-1:0]   scanVal;
    logic                   takeNew;
    logic [indexWidth-1:0]  nextIdx;
    logic [dataWidth-1:0]   nextVal;
    logic                   allReported;
    logic                   lastIdx;

    // A neuron is captured only on its first valid while gathering.
    genvar gi;
    generate
        for (gi = 0; gi < numNeurons; gi++) begin : g_cap
            assign capEn[gi] = (state == COLLECT) && !clear && layerInValid[gi] && !gotFlag[gi];

            // Capture storage carries no reset; it is only observed after a full scan.
            always_ff @(posedge clk) begin
                if (capEn[gi]) begin
                    capReg[gi] <= layerIn[gi*dataWidth +: dataWidth];
                end
            end
        end
    endgenerate

    assign allReported = &(gotFlag | layerInValid);
    assign lastIdx     = (scanIdx == indexWidth'(numNeurons - 1));
    assign scanVal     = capReg[scanIdx];
    // Strict compare keeps the earliest index on ties; element 0 always seeds.
    assign takeNew     = (scanIdx == '0) || (scanVal > bestVal);
    assign nextIdx     = takeNew ? scanIdx : bestIdx;
    assign nextVal     = takeNew ? scanVal : bestVal;

    // Sequencer: gather flags, scan running maximum, hold result until accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= COLLECT;
            gotFlag    <= '0;
            scanIdx    <= '0;
            bestIdx    <= '0;
            bestVal    <= '0;
            classOut   <= '0;
            maxOut     <= '0;
            classValid <= 1'b0;
            busy       <= 1'b0;
        end else if (clear) begin
            state      <= COLLECT;
            gotFlag    <= '0;
            classValid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    gotFlag <= gotFlag | layerInValid;
                    if (allReported) begin
                        state   <= SCAN;
                        scanIdx <= '0;
                        bestIdx <= '0;
                        bestVal <= '0;
                        busy    <= 1'b1;
                    end
                end
                SCAN: begin
                    bestIdx <= nextIdx;
                    bestVal <= nextVal;
                    if (lastIdx) begin
                        state      <= DONE;
                        classOut   <= nextIdx;
                        maxOut     <= nextVal;
                        classValid <= 1'b1;
                    end else begin
                        scanIdx <= scanIdx + indexWidth'(1);
                    end
                end
                DONE: begin
                    if (classReady) begin
                        state      <= COLLECT;
                        gotFlag    <= '0;
                        classValid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_argmax.sv
// Directed bench for layer_argmax with hand-computed expected results.
module tb_layer_argmax;

    localparam int N  = 10;
    localparam int DW = 8;
    localparam int IW = $clog2(N);

    logic              clk;
    logic              reset_n;
    logic              clear;
    logic [N*DW-1:0]   layerIn;
    logic [N-1:0]      layerInValid;
    logic [IW-1:0]     classOut;
    logic [DW-1:0]     maxOut;
    logic              classValid;
    logic              classReady;
    logic              busy;

    int assertCount = 0;
    int failCount   = 0;

    layer_argmax #(.numNeurons(N), .dataWidth(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .layerIn      (layerIn),
        .layerInValid (layerInValid),
        .classOut     (classOut),
        .maxOut       (maxOut),
        .classValid   (classValid),
        .classReady   (classReady),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadVec(input int v [N]);
        for (int i = 0; i < N; i++) layerIn[i*DW +: DW] = DW'(v[i]);
    endtask

    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (classValid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; layerIn = '0; layerInValid = '0; classReady = 1'b0;
        tick(); tick();
        assertCount++;
        if ({classValid, busy, classOut, maxOut} !== '0) begin
            failCount++;
            $display("FAIL reset_outputs: got valid=%0b busy=%0b class=%0d max=%0d, expected all 0", classValid, busy, classOut, maxOut);
        end
        reset_n = 1'b1;
        tick();
        assertCount++;
        if (busy !== 1'b0 || classValid !== 1'b0) begin
            failCount++;
            $display("FAIL reset_release: got busy=%0b valid=%0b, expected 0 0", busy, classValid);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int cyc;
        loadVec('{3, 9, 200, 7, 0, 0, 0, 0, 0, 1});
        classReady = 1'b1;
        layerInValid = '1;
        tick();                       // capture edge k
        layerInValid = '0;
        assertCount++;
        if (busy !== 1'b1) begin
            failCount++;
            $display("FAIL single_busy: got %0b expected 1", busy);
        end
        cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (classValid) begin
                cyc = c;
                break;
            end
        end
        assertCount++;
        if (cyc != 10) begin
            failCount++;
            $display("FAIL single_latency: got %0d cycles expected 10", cyc);
        end
        assertCount++;
        if (classOut !== 4'd2 || maxOut !== 8'd200) begin
            failCount++;
            $display("FAIL single_result: got class=%0d max=%0d expected 2 200", classOut, maxOut);
        end
        tick();
        assertCount++;
        if (classValid !== 1'b0 || busy !== 1'b0) begin
            failCount++;
            $display("FAIL single_pulse: got valid=%0b busy=%0b expected 0 0", classValid, busy);
        end
        $display("test_single class=%0d max=%0d latency=%0d", classOut, maxOut, cyc);
    endtask

    task automatic test_staggered();
        bit ok;
        loadVec('{5, 5, 5, 5, 5, 5, 5, 5, 5, 80});
        classReady = 1'b1;
        layerInValid = 10'b10_0000_0000;
        tick();
        layerIn[9*DW +: DW] = 8'd1;   // later data on an already-captured neuron
        for (int i = 8; i >= 0; i--) begin
            layerInValid[i] = 1'b1;
            tick();
            if (i > 0) begin
                assertCount++;
                if (busy !== 1'b0) begin
                    failCount++;
                    $display("FAIL stagger_early_scan_%0d: got busy=%0b expected 0", i, busy);
                end
            end
        end
        assertCount++;
        if (busy !== 1'b1) begin
            failCount++;
            $display("FAIL stagger_scan_start: got busy=%0b expected 1", busy);
        end
        layerInValid = '0;
        waitValid(ok);
        assertCount++;
        if (!ok || classOut !== 4'd9 || maxOut !== 8'd80) begin
            failCount++;
            $display("FAIL stagger_result: got ok=%0b class=%0d max=%0d expected 1 9 80", ok, classOut, maxOut);
        end
        tick();
        $display("test_staggered class=%0d max=%0d", classOut, maxOut);
    endtask

    task automatic test_tie_zero();
        bit ok;
        classReady = 1'b1;
        loadVec('{0, 44, 12, 44, 3, 0, 44, 1, 2, 0});
        layerInValid = '1;
        tick();
        layerInValid = '0;
        waitValid(ok);
        assertCount++;
        if (!ok || classOut !== 4'd1 || maxOut !== 8'd44) begin
            failCount++;
            $display("FAIL tie_result: got ok=%0b class=%0d max=%0d expected 1 1 44", ok, classOut, maxOut);
        end
        tick();
        loadVec('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        layerInValid = '1;
        tick();
        layerInValid = '0;
        waitValid(ok);
        assertCount++;
        if (!ok || classOut !== 4'd0 || maxOut !== 8'd0) begin
            failCount++;
            $display("FAIL zero_result: got ok=%0b class=%0d max=%0d expected 1 0 0", ok, classOut, maxOut);
        end
        tick();
        $display("test_tie_zero class=%0d max=%0d", classOut, maxOut);
    endtask

    task automatic test_backpressure();
        bit ok;
        classReady = 1'b0;
        loadVec('{10, 20, 30, 40, 50, 60, 70, 80, 90, 100});
        layerInValid = '1;
        tick();
        layerInValid = '0;
        waitValid(ok);
        assertCount++;
        if (!ok || classOut !== 4'd9 || maxOut !== 8'd100) begin
            failCount++;
            $display("FAIL bp_result: got ok=%0b class=%0d max=%0d expected 1 9 100", ok, classOut, maxOut);
        end
        for (int c = 0; c < 20; c++) begin
            loadVec('{250, 251, 252, 253, 254, 255, 1, 2, 3, 4});
            layerInValid = (c % 2 == 0) ? '1 : 10'b00_0000_0001;
            tick();
            assertCount++;
            if (classValid !== 1'b1 || classOut !== 4'd9 || maxOut !== 8'd100) begin
                failCount++;
                $display("FAIL bp_hold_%0d: got valid=%0b class=%0d max=%0d expected 1 9 100", c, classValid, classOut, maxOut);
            end
        end
        layerInValid = '0;
        classReady = 1'b1;
        tick();                       // acceptance edge m
        assertCount++;
        if (classValid !== 1'b0 || busy !== 1'b0) begin
            failCount++;
            $display("FAIL bp_accept: got valid=%0b busy=%0b expected 0 0", classValid, busy);
        end
        loadVec('{0, 0, 0, 0, 0, 0, 0, 0, 0, 255});
        layerInValid = '1;
        tick();
        layerInValid = '0;
        waitValid(ok);
        assertCount++;
        if (!ok || classOut !== 4'd9 || maxOut !== 8'd255) begin
            failCount++;
            $display("FAIL bp_next: got ok=%0b class=%0d max=%0d expected 1 9 255", ok, classOut, maxOut);
        end
        tick();
        $display("test_backpressure class=%0d max=%0d", classOut, maxOut);
    endtask

    task automatic test_clear();
        bit ok;
        bit seen;
        classReady = 1'b1;
        loadVec('{1, 2, 3, 4, 5, 6, 99, 7, 8, 9});
        layerInValid = '1;
        tick();                       // capture edge
        layerInValid = '0;
        tick(); tick(); tick();       // SCAN cycles 1..3
        clear = 1'b1;
        tick();
        clear = 1'b0;
        assertCount++;
        if (busy !== 1'b0 || classValid !== 1'b0) begin
            failCount++;
            $display("FAIL clear_scan: got busy=%0b valid=%0b expected 0 0", busy, classValid);
        end
        seen = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (classValid || busy) seen = 1'b1;
        end
        assertCount++;
        if (seen) begin
            failCount++;
            $display("FAIL clear_quiet: got activity=1 expected 0");
        end
        layerInValid = '1;
        tick();
        layerInValid = '0;
        waitValid(ok);
        assertCount++;
        if (!ok || classOut !== 4'd6 || maxOut !== 8'd99) begin
            failCount++;
            $display("FAIL clear_redo: got ok=%0b class=%0d max=%0d expected 1 6 99", ok, classOut, maxOut);
        end
        classReady = 1'b0;            // hold result so the reset test sees nonzero outputs
        $display("test_clear class=%0d max=%0d", classOut, maxOut);
    endtask

    task automatic test_reset_midscan();
        bit ok;
        classReady = 1'b1;
        tick();                       // accept held result
        loadVec('{0, 0, 0, 50, 0, 0, 0, 0, 0, 0});
        layerInValid = '1;
        tick();
        layerInValid = '0;
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        assertCount++;
        if ({classValid, busy, classOut, maxOut} !== '0) begin
            failCount++;
            $display("FAIL async_reset: got valid=%0b busy=%0b class=%0d max=%0d expected all 0", classValid, busy, classOut, maxOut);
        end
        #2 reset_n = 1'b1;
        loadVec('{0, 0, 0, 0, 0, 0, 0, 0, 77, 0});
        layerInValid = '1;
        tick();
        layerInValid = '0;
        waitValid(ok);
        assertCount++;
        if (!ok || classOut !== 4'd8 || maxOut !== 8'd77) begin
            failCount++;
            $display("FAIL reset_recover: got ok=%0b class=%0d max=%0d expected 1 8 77", ok, classOut, maxOut);
        end
        tick();
        $display("test_reset_midscan class=%0d max=%0d", classOut, maxOut);
    endtask

    task automatic test_clear_accept();
        bit ok;
        bit seen;
        classReady = 1'b0;
        loadVec('{7, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        layerInValid = '1;
        tick();
        layerInValid = '0;
        waitValid(ok);
        assertCount++;
        if (!ok || classOut !== 4'd0 || maxOut !== 8'd7) begin
            failCount++;
            $display("FAIL ca_result: got ok=%0b class=%0d max=%0d expected 1 0 7", ok, classOut, maxOut);
        end
        clear = 1'b1;
        classReady = 1'b1;
        tick();
        clear = 1'b0;
        classReady = 1'b0;
        assertCount++;
        if (classValid !== 1'b0 || busy !== 1'b0) begin
            failCount++;
            $display("FAIL ca_priority: got valid=%0b busy=%0b expected 0 0", classValid, busy);
        end
        seen = 1'b0;
        for (int c = 0; c < 13; c++) begin
            tick();
            if (classValid) seen = 1'b1;
        end
        assertCount++;
        if (seen) begin
            failCount++;
            $display("FAIL ca_no_extra: got extra valid=1 expected 0");
        end
        loadVec('{1, 2, 3, 4, 5, 6, 7, 8, 9, 33});
        layerInValid = 10'b01_1111_1111;
        tick();
        layerInValid = '0;
        assertCount++;
        if (busy !== 1'b0) begin
            failCount++;
            $display("FAIL ca_flags_cleared: got busy=%0b expected 0", busy);
        end
        layerInValid = 10'b10_0000_0000;
        tick();
        layerInValid = '0;
        waitValid(ok);
        assertCount++;
        if (!ok || classOut !== 4'd9 || maxOut !== 8'd33) begin
            failCount++;
            $display("FAIL ca_next: got ok=%0b class=%0d max=%0d expected 1 9 33", ok, classOut, maxOut);
        end
        classReady = 1'b1;
        tick();
        $display("test_clear_accept class=%0d max=%0d", classOut, maxOut);
    endtask

    initial begin
        test_reset();
        test_single();
        test_staggered();
        test_tie_zero();
        test_backpressure();
        test_clear();
        test_reset_midscan();
        test_clear_accept();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
